// File: rtl/trigger_crossbar_matrix.sv
// Parametrised NUM_IN x NUM_OUT trigger routing matrix: each output picks one synchronised input and
// applies an off / direct / fixed-width pulse / edge-with-holdoff mode; LED stretchers show activity.
module trigger_crossbar_matrix #(
   parameter int NUM_IN        = 12,
   parameter int NUM_OUT       = 12,
   parameter int COUNT_WIDTH   = 16,
   parameter int STRETCH_WIDTH = 22
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_IN-1:0]  trig_in,
   input  logic               cfg_wr_en,
   input  logic [7:0]         cfg_addr,
   input  logic [31:0]        cfg_wr_data,
   output logic [31:0]        cfg_rd_data,
   output logic [NUM_OUT-1:0] trig_out,
   output logic [NUM_IN-1:0]  trig_in_led,
   output logic [NUM_OUT-1:0] trig_out_led
);

   localparam int SEL_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int PAD_W = 1 << SEL_W;

   localparam logic [1:0] MODE_OFF     = 2'd0;
   localparam logic [1:0] MODE_DIRECT  = 2'd1;
   localparam logic [1:0] MODE_PULSE   = 2'd2;
   localparam logic [1:0] MODE_HOLDOFF = 2'd3;

   localparam logic [COUNT_WIDTH-1:0]   CNT_ZERO = {COUNT_WIDTH{1'b0}};
   localparam logic [COUNT_WIDTH-1:0]   CNT_ONE  = COUNT_WIDTH'(1'b1);
   localparam logic [STRETCH_WIDTH-1:0] STR_ZERO = {STRETCH_WIDTH{1'b0}};
   localparam logic [STRETCH_WIDTH-1:0] STR_ONE  = STRETCH_WIDTH'(1'b1);
   localparam logic [STRETCH_WIDTH-1:0] STR_ONES = {STRETCH_WIDTH{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_DEAD   = 2'd2
   } state_e;

   typedef struct packed {
      logic [COUNT_WIDTH-1:0] count;
      logic                   inv;
      logic [1:0]             mode;
      logic [7:0]             sel;
   } cfg_t;

   localparam cfg_t CFG_RESET = '{count: CNT_ZERO, inv: 1'b0, mode: MODE_OFF, sel: 8'd0};

   function automatic logic [31:0] pack_cfg(input cfg_t c);
      logic [31:0] w;
      w = 32'd0;
      w[7:0] = c.sel;
      w[9:8] = c.mode;
      w[10] = c.inv;
      w[16 +: COUNT_WIDTH] = c.count;
      return w;
   endfunction

   function automatic logic [STRETCH_WIDTH-1:0] stretch_next(input logic src,
                                                             input logic [STRETCH_WIDTH-1:0] cnt);
      logic [STRETCH_WIDTH-1:0] n;
      if (src) begin
         n = STR_ONES;
      end else if (cnt != STR_ZERO) begin
         n = cnt - STR_ONE;
      end else begin
         n = STR_ZERO;
      end
      return n;
   endfunction

   logic [NUM_IN-1:0]        sync1_q, sync1_d, s_q, s_d, p_q, p_d;
   logic [PAD_W-1:0]         s_pad, p_pad;
   cfg_t                     cfg_q [NUM_OUT];
   cfg_t                     cfg_d [NUM_OUT];
   state_e                   state_q [NUM_OUT];
   state_e                   state_d [NUM_OUT];
   logic [COUNT_WIDTH-1:0]   cnt_q [NUM_OUT];
   logic [COUNT_WIDTH-1:0]   cnt_d [NUM_OUT];
   logic [STRETCH_WIDTH-1:0] in_str_q [NUM_IN];
   logic [STRETCH_WIDTH-1:0] in_str_d [NUM_IN];
   logic [STRETCH_WIDTH-1:0] out_str_q [NUM_OUT];
   logic [STRETCH_WIDTH-1:0] out_str_d [NUM_OUT];
   logic [NUM_OUT-1:0]       trig_out_q, trig_out_d;
   logic [NUM_IN-1:0]        trig_in_led_q, trig_in_led_d;
   logic [NUM_OUT-1:0]       trig_out_led_q, trig_out_led_d;
   logic [31:0]              cfg_rd_data_q, cfg_rd_data_d;
   logic [NUM_OUT-1:0]       wr_hit, x_sel, px_sel, rise;
   logic                     wr_ok;
   logic [31:0]              rd_word;
   logic                     unused_wr_bits;

   assign unused_wr_bits = ^cfg_wr_data[15:11];

   // Two-flop synchroniser plus one-cycle delayed copy for edge detection
   always_comb begin
      sync1_d = trig_in;
      s_d     = sync1_q;
      p_d     = s_q;
      s_pad   = PAD_W'(s_q);
      p_pad   = PAD_W'(p_q);
   end

   // Config write decode and readback of the post-write value
   always_comb begin
      wr_hit  = {NUM_OUT{1'b0}};
      wr_ok   = cfg_wr_en & ({1'b0, cfg_addr} < 9'(NUM_OUT));
      rd_word = 32'd0;
      for (int o = 0; o < NUM_OUT; o++) begin
         if (wr_ok && (cfg_addr == 8'(o))) begin
            wr_hit[o] = 1'b1;
            cfg_d[o]  = '{count: cfg_wr_data[16 +: COUNT_WIDTH], inv: cfg_wr_data[10],
                          mode: cfg_wr_data[9:8], sel: cfg_wr_data[7:0]};
         end else begin
            cfg_d[o] = cfg_q[o];
         end
         rd_word = rd_word | ((cfg_addr == 8'(o)) ? pack_cfg(cfg_d[o]) : 32'd0);
      end
      cfg_rd_data_d = rd_word;
   end

   // Input selection; the range check uses the full 8-bit sel before truncation
   always_comb begin
      for (int o = 0; o < NUM_OUT; o++) begin
         if ({1'b0, cfg_q[o].sel} < 9'(NUM_IN)) begin
            x_sel[o]  = s_pad[cfg_q[o].sel[SEL_W-1:0]] ^ cfg_q[o].inv;
            px_sel[o] = p_pad[cfg_q[o].sel[SEL_W-1:0]] ^ cfg_q[o].inv;
         end else begin
            x_sel[o]  = 1'b0;
            px_sel[o] = 1'b0;
         end
         rise[o] = x_sel[o] & ~px_sel[o];
      end
   end

   // Per-output mode state machine; any write to the output aborts it
   always_comb begin
      for (int o = 0; o < NUM_OUT; o++) begin
         state_d[o]    = state_q[o];
         cnt_d[o]      = cnt_q[o];
         trig_out_d[o] = 1'b0;
         if (wr_hit[o]) begin
            state_d[o] = ST_IDLE;
            cnt_d[o]   = CNT_ZERO;
         end else begin
            case (cfg_q[o].mode)
               MODE_DIRECT: begin
                  state_d[o]    = ST_IDLE;
                  cnt_d[o]      = CNT_ZERO;
                  trig_out_d[o] = x_sel[o];
               end
               MODE_PULSE: begin
                  case (state_q[o])
                     ST_IDLE: begin
                        if (rise[o]) begin
                           state_d[o]    = ST_ACTIVE;
                           cnt_d[o]      = cfg_q[o].count;
                           trig_out_d[o] = 1'b1;
                        end else begin
                           cnt_d[o] = CNT_ZERO;
                        end
                     end
                     ST_ACTIVE: begin
                        if (cnt_q[o] != CNT_ZERO) begin
                           cnt_d[o]      = cnt_q[o] - CNT_ONE;
                           trig_out_d[o] = 1'b1;
                        end else begin
                           state_d[o] = ST_IDLE;
                        end
                     end
                     default: begin
                        state_d[o] = ST_IDLE;
                        cnt_d[o]   = CNT_ZERO;
                     end
                  endcase
               end
               MODE_HOLDOFF: begin
                  case (state_q[o])
                     ST_IDLE: begin
                        if (rise[o]) begin
                           state_d[o]    = ST_ACTIVE;
                           cnt_d[o]      = cfg_q[o].count;
                           trig_out_d[o] = 1'b1;
                        end else begin
                           cnt_d[o] = CNT_ZERO;
                        end
                     end
                     ST_ACTIVE: begin
                        if (cnt_q[o] != CNT_ZERO) begin
                           state_d[o] = ST_DEAD;
                        end else begin
                           state_d[o] = ST_IDLE;
                        end
                     end
                     ST_DEAD: begin
                        // leave on the cycle cnt reaches 0 so an edge there is still dropped
                        if (cnt_q[o] > CNT_ONE) begin
                           cnt_d[o] = cnt_q[o] - CNT_ONE;
                        end else begin
                           cnt_d[o]   = CNT_ZERO;
                           state_d[o] = ST_IDLE;
                        end
                     end
                     default: begin
                        state_d[o] = ST_IDLE;
                        cnt_d[o]   = CNT_ZERO;
                     end
                  endcase
               end
               default: begin
                  state_d[o] = ST_IDLE;
                  cnt_d[o]   = CNT_ZERO;
               end
            endcase
         end
      end
   end

   // LED stretchers: LED reflects the source or a still-running counter one cycle later
   always_comb begin
      for (int i = 0; i < NUM_IN; i++) begin
         in_str_d[i]      = stretch_next(s_q[i], in_str_q[i]);
         trig_in_led_d[i] = s_q[i] | (in_str_q[i] != STR_ZERO);
      end
      for (int o = 0; o < NUM_OUT; o++) begin
         out_str_d[o]      = stretch_next(trig_out_q[o], out_str_q[o]);
         trig_out_led_d[o] = trig_out_q[o] | (out_str_q[o] != STR_ZERO);
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q        <= {NUM_IN{1'b0}};
         s_q            <= {NUM_IN{1'b0}};
         p_q            <= {NUM_IN{1'b0}};
         trig_out_q     <= {NUM_OUT{1'b0}};
         trig_in_led_q  <= {NUM_IN{1'b0}};
         trig_out_led_q <= {NUM_OUT{1'b0}};
         cfg_rd_data_q  <= 32'd0;
         for (int o = 0; o < NUM_OUT; o++) begin
            cfg_q[o]     <= CFG_RESET;
            state_q[o]   <= ST_IDLE;
            cnt_q[o]     <= CNT_ZERO;
            out_str_q[o] <= STR_ZERO;
         end
         for (int i = 0; i < NUM_IN; i++) begin
            in_str_q[i] <= STR_ZERO;
         end
      end else begin
         sync1_q        <= sync1_d;
         s_q            <= s_d;
         p_q            <= p_d;
         trig_out_q     <= trig_out_d;
         trig_in_led_q  <= trig_in_led_d;
         trig_out_led_q <= trig_out_led_d;
         cfg_rd_data_q  <= cfg_rd_data_d;
         for (int o = 0; o < NUM_OUT; o++) begin
            cfg_q[o]     <= cfg_d[o];
            state_q[o]   <= state_d[o];
            cnt_q[o]     <= cnt_d[o];
            out_str_q[o] <= out_str_d[o];
         end
         for (int i = 0; i < NUM_IN; i++) begin
            in_str_q[i] <= in_str_d[i];
         end
      end
   end

   assign trig_out     = trig_out_q;
   assign trig_in_led  = trig_in_led_q;
   assign trig_out_led = trig_out_led_q;
   assign cfg_rd_data  = cfg_rd_data_q;

endmodule

// File: tb/tb_trigger_crossbar_matrix.sv
// Scoreboard bench for trigger_crossbar_matrix: stimulus queues per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_trigger_crossbar_matrix;

   localparam int NI = 12;
   localparam int NO = 12;
   localparam int CW = 16;
   localparam int SW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [NI-1:0] trig_in;
   logic          cfg_wr_en;
   logic [7:0]    cfg_addr;
   logic [31:0]   cfg_wr_data;
   logic [31:0]   cfg_rd_data;
   logic [NO-1:0] trig_out;
   logic [NI-1:0] trig_in_led;
   logic [NO-1:0] trig_out_led;

   trigger_crossbar_matrix #(
      .NUM_IN(NI), .NUM_OUT(NO), .COUNT_WIDTH(CW), .STRETCH_WIDTH(SW)
   ) dut (
      .clk(clk), .rst(rst), .trig_in(trig_in), .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr),
      .cfg_wr_data(cfg_wr_data), .cfg_rd_data(cfg_rd_data), .trig_out(trig_out),
      .trig_in_led(trig_in_led), .trig_out_led(trig_out_led)
   );

   always #5 clk = ~clk;

   // kind: 0 trig_out, 1 trig_in_led, 2 trig_out_led, 3 cfg_rd_data
   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] mask;
      logic [31:0] exp;
   } chk_t;

   chk_t sb[$];
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic string kname(input int k);
      case (k)
         0: return "trig_out";
         1: return "trig_in_led";
         2: return "trig_out_led";
         3: return "cfg_rd_data";
         default: return "unknown";
      endcase
   endfunction

   task automatic exp_word(input int c, input int kind, input logic [31:0] mask, input logic [31:0] val);
      sb.push_back('{cyc: c, kind: kind, mask: mask, exp: val & mask});
   endtask

   task automatic exp_range(input int c0, input int c1, input int kind, input int idx, input logic v);
      for (int c = c0; c <= c1; c++) begin
         sb.push_back('{cyc: c, kind: kind, mask: 32'd1 << idx, exp: {31'd0, v} << idx});
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
      cfg_wr_en   = 1'b1;
      cfg_addr    = a;
      cfg_wr_data = d;
      step(1);
      cfg_wr_en   = 1'b0;
   endtask

   // Monitor: compare every expectation scheduled for the current cycle
   initial begin
      logic [31:0] act;
      forever begin
         @(negedge clk);
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
               case (sb[i].kind)
                  0: act = 32'(trig_out);
                  1: act = 32'(trig_in_led);
                  2: act = 32'(trig_out_led);
                  3: act = cfg_rd_data;
                  default: act = 32'hDEAD_BEEF;
               endcase
               act = act & sb[i].mask;
               n_tests++;
               if (act !== sb[i].exp) begin
                  n_fail++;
                  $display("FAIL %s cycle %0d mask %h: got %h expected %h",
                           kname(sb[i].kind), cyc, sb[i].mask, act, sb[i].exp);
               end
               sb.delete(i);
            end
         end
      end
   end

   initial begin
      int t0, t1, w;
      logic [7:0] pat;
      rst         = 1'b1;
      trig_in     = '0;
      cfg_wr_en   = 1'b0;
      cfg_addr    = 8'd0;
      cfg_wr_data = 32'd0;

      // reset state
      step(2);
      for (int c = cyc; c <= cyc + 1; c++) begin
         exp_word(c, 0, 32'hFFF, 32'd0);
         exp_word(c, 1, 32'hFFF, 32'd0);
         exp_word(c, 2, 32'hFFF, 32'd0);
         exp_word(c, 3, 32'hFFFF_FFFF, 32'd0);
      end
      step(2);
      rst = 1'b0;
      step(2);

      // reset in the middle of a long pulse
      cfg_write(8'd0, 32'h0064_0200);
      t0 = cyc;
      trig_in[0] = 1'b1;
      exp_range(t0 + 2, t0 + 2, 0, 0, 1'b0);
      exp_range(t0 + 3, t0 + 52, 0, 0, 1'b1);
      exp_word(t0 + 10, 3, 32'hFFFF_FFFF, 32'h0064_0200);
      exp_range(t0 + 52, t0 + 52, 2, 0, 1'b1);
      step(1);
      trig_in[0] = 1'b0;
      step(t0 + 53 - cyc);
      rst = 1'b1;
      exp_word(cyc, 0, 32'hFFF, 32'd0);
      exp_word(cyc, 1, 32'hFFF, 32'd0);
      exp_word(cyc, 2, 32'hFFF, 32'd0);
      step(2);
      rst = 1'b0;
      exp_range(cyc + 1, cyc + 70, 0, 0, 1'b0);
      exp_word(cyc + 2, 3, 32'hFFFF_FFFF, 32'd0);
      step(72);

      // DIRECT out3 <- in5
      cfg_write(8'd3, 32'h0000_0105);
      t0 = cyc;
      trig_in[5] = 1'b1;
      exp_range(t0 + 2, t0 + 2, 0, 3, 1'b0);
      exp_range(t0 + 3, t0 + 6, 0, 3, 1'b1);
      exp_range(t0 + 7, t0 + 9, 0, 3, 1'b0);
      step(4);
      trig_in[5] = 1'b0;
      step(6);

      // DIRECT with invert
      w = cyc;
      cfg_write(8'd3, 32'h0000_0505);
      exp_range(w + 1, w + 1, 0, 3, 1'b0);
      exp_range(w + 2, w + 5, 0, 3, 1'b1);
      exp_range(w + 6, w + 8, 0, 3, 1'b0);
      exp_range(w + 9, w + 11, 0, 3, 1'b1);
      step(2);
      trig_in[5] = 1'b1;
      step(3);
      trig_in[5] = 1'b0;
      step(6);

      // sel out of range with invert: output held low
      w = cyc;
      cfg_write(8'd3, 32'h0000_050C);
      exp_range(w + 1, w + 15, 0, 3, 1'b0);
      for (int i = 0; i < 15; i++) begin
         trig_in = (i % 6 >= 1 && i % 6 <= 3) ? 12'hFFF : 12'h000;
         step(1);
      end
      trig_in = '0;
      step(25);

      // PULSE count=4: ignored retrigger, accepted edge right after the pulse
      cfg_write(8'd1, 32'h0004_0202);
      t0 = cyc;
      pat = 8'b0100_0101;
      exp_range(t0 + 2, t0 + 2, 0, 1, 1'b0);
      exp_range(t0 + 3, t0 + 7, 0, 1, 1'b1);
      exp_range(t0 + 8, t0 + 8, 0, 1, 1'b0);
      exp_range(t0 + 9, t0 + 13, 0, 1, 1'b1);
      exp_range(t0 + 14, t0 + 17, 0, 1, 1'b0);
      for (int i = 0; i < 8; i++) begin
         trig_in[2] = pat[i];
         step(1);
      end
      step(12);

      // HOLDOFF count=10, edges at 0, 5, 12
      cfg_write(8'd2, 32'h000A_0307);
      t0 = cyc;
      exp_range(t0 + 2, t0 + 2, 0, 2, 1'b0);
      exp_range(t0 + 3, t0 + 3, 0, 2, 1'b1);
      exp_range(t0 + 4, t0 + 14, 0, 2, 1'b0);
      exp_range(t0 + 15, t0 + 15, 0, 2, 1'b1);
      exp_range(t0 + 16, t0 + 18, 0, 2, 1'b0);
      for (int i = 0; i < 14; i++) begin
         trig_in[7] = (i == 0 || i == 5 || i == 12);
         step(1);
      end
      step(8);

      // config abort mid-pulse, same-cycle readback, out-of-range address
      cfg_write(8'd0, 32'h0064_0200);
      t0 = cyc;
      trig_in[0] = 1'b1;
      exp_range(t0 + 3, t0 + 6, 0, 0, 1'b1);
      step(1);
      trig_in[0] = 1'b0;
      step(5);
      exp_word(cyc, 3, 32'hFFFF_FFFF, 32'h0064_0200);
      exp_range(cyc + 1, cyc + 8, 0, 0, 1'b0);
      exp_word(cyc + 1, 3, 32'hFFFF_FFFF, 32'h0003_0200);
      cfg_write(8'd0, 32'h0003_0200);
      cfg_addr = 8'd200;
      exp_word(cyc + 1, 3, 32'hFFFF_FFFF, 32'd0);
      step(1);
      cfg_addr = 8'd0;
      exp_word(cyc + 1, 3, 32'hFFFF_FFFF, 32'h0003_0200);
      step(1);
      cfg_write(8'd16, 32'h0000_0103);
      cfg_addr = 8'd0;
      exp_word(cyc + 1, 3, 32'hFFFF_FFFF, 32'h0003_0200);
      step(1);
      cfg_addr = 8'd16;
      exp_word(cyc + 1, 3, 32'hFFFF_FFFF, 32'd0);
      step(1);
      exp_word(cyc + 1, 3, 32'hFFFF_FFFF, 32'hFFFF_07FF);
      cfg_write(8'd4, 32'hFFFF_FFFF);
      step(12);

      // LED stretch: single-cycle input and routed output, then a held input
      cfg_write(8'd5, 32'h0000_0109);
      t0 = cyc;
      trig_in[9] = 1'b1;
      exp_range(t0 + 2, t0 + 2, 1, 9, 1'b0);
      exp_range(t0 + 3, t0 + 18, 1, 9, 1'b1);
      exp_range(t0 + 19, t0 + 19, 1, 9, 1'b0);
      exp_range(t0 + 3, t0 + 3, 0, 5, 1'b1);
      exp_range(t0 + 4, t0 + 4, 0, 5, 1'b0);
      exp_range(t0 + 3, t0 + 3, 2, 5, 1'b0);
      exp_range(t0 + 4, t0 + 19, 2, 5, 1'b1);
      exp_range(t0 + 20, t0 + 20, 2, 5, 1'b0);
      step(1);
      trig_in[9] = 1'b0;
      step(24);
      t1 = cyc;
      trig_in[10] = 1'b1;
      exp_range(t1 + 2, t1 + 2, 1, 10, 1'b0);
      exp_range(t1 + 3, t1 + 47, 1, 10, 1'b1);
      exp_range(t1 + 48, t1 + 48, 1, 10, 1'b0);
      step(30);
      trig_in[10] = 1'b0;

      for (int k = 0; k < 400 && sb.size() != 0; k++) begin
         step(1);
      end
      if (sb.size() != 0) begin
         for (int i = 0; i < sb.size(); i++) begin
            n_tests++;
            n_fail++;
            $display("FAIL timeout %s: check for cycle %0d never evaluated, now cycle %0d",
                     kname(sb[i].kind), sb[i].cyc, cyc);
         end
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
